cfu_issue: RTL and testbench

- Issue/hold stage between the CPU execute stage and a multi-cycle CFU backend.
- Captures the CFU instruction's control and operands, and runs a valid/ready request handshake plus a result-valid return handshake with the backend.
- Stalls the pipeline until the result is available, then holds the result stable while the pipeline itself is stalled.
- Adds a timeout watchdog so that a hung backend cannot freeze the core.

---
 rtl/cfu_issue_pkg.sv | 14 +
 rtl/cfu_issue_timeout_ctr.sv | 36 +++
 rtl/cfu_issue.sv | 128 ++++++++++++
 tb/tb_cfu_issue.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/cfu_issue_pkg.sv
// Shared widths and state type for the CFU issue/hold stage.
package cfu_issue_pkg;

  localparam int CFU_XLEN       = 32;
  localparam int CFU_CTRL_WIDTH = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } cfu_state_e;

endpackage

// File: rtl/cfu_issue_timeout_ctr.sv
// Saturating cycle counter for the CFU watchdog; expire_o is high at TIMEOUT-1.
module cfu_issue_timeout_ctr #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i && (count_q != LAST)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = (count_q == LAST);

endmodule

// File: rtl/cfu_issue.sv
// Issue/hold stage between EX and a multi-cycle CFU backend, with a watchdog
// that forces completion (result 0, sticky err_o) if the backend hangs.
module cfu_issue
  import cfu_issue_pkg::*;
#(
  parameter int XLEN       = CFU_XLEN,
  parameter int CTRL_WIDTH = CFU_CTRL_WIDTH,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  stall_i,
  input  logic                  valid_i,
  input  logic [CTRL_WIDTH-1:0] cfu_ctrl_i,
  input  logic [XLEN-1:0]       src1_i,
  input  logic [XLEN-1:0]       src2_i,
  output logic                  stall_o,
  output logic [XLEN-1:0]       rslt_o,
  output logic                  err_o,
  output logic                  req_valid_o,
  output logic [CTRL_WIDTH-1:0] req_ctrl_o,
  output logic [XLEN-1:0]       req_src1_o,
  output logic [XLEN-1:0]       req_src2_o,
  input  logic                  req_ready_i,
  input  logic                  rsp_valid_i,
  input  logic [XLEN-1:0]       rsp_data_i
);

  cfu_state_e            state_q, state_d;
  logic                  req_valid_q, req_valid_d;
  logic [CTRL_WIDTH-1:0] req_ctrl_q, req_ctrl_d;
  logic [XLEN-1:0]       req_src1_q, req_src1_d;
  logic [XLEN-1:0]       req_src2_q, req_src2_d;
  logic [XLEN-1:0]       rslt_q, rslt_d;
  logic                  err_q, err_d;

  logic busy;
  logic rsp_hit;
  logic ctr_clear;
  logic expire;

  assign busy      = (state_q == ST_REQ) || (state_q == ST_WAIT);
  // In REQ a response only counts together with the request being accepted.
  assign rsp_hit   = rsp_valid_i && ((state_q == ST_WAIT) || req_ready_i);
  assign ctr_clear = (state_q == ST_IDLE) && valid_i;

  cfu_issue_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (ctr_clear),
    .en_i     (busy),
    .expire_o (expire)
  );

  always_comb begin
    state_d     = state_q;
    req_valid_d = req_valid_q;
    req_ctrl_d  = req_ctrl_q;
    req_src1_d  = req_src1_q;
    req_src2_d  = req_src2_q;
    rslt_d      = rslt_q;
    err_d       = err_q;

    case (state_q)
      ST_IDLE: begin
        if (valid_i) begin
          req_ctrl_d  = cfu_ctrl_i;
          req_src1_d  = src1_i;
          req_src2_d  = src2_i;
          req_valid_d = 1'b1;
          state_d     = ST_REQ;
        end
      end
      ST_REQ, ST_WAIT: begin
        if (rsp_hit) begin
          rslt_d      = rsp_data_i;
          req_valid_d = 1'b0;
          state_d     = ST_DONE;
        end else if (expire) begin
          rslt_d      = '0;
          err_d       = 1'b1;
          req_valid_d = 1'b0;
          state_d     = ST_DONE;
        end else if ((state_q == ST_REQ) && req_ready_i) begin
          req_valid_d = 1'b0;
          state_d     = ST_WAIT;
        end
      end
      ST_DONE: begin
        if (!stall_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      req_valid_q <= 1'b0;
      req_ctrl_q  <= '0;
      req_src1_q  <= '0;
      req_src2_q  <= '0;
      rslt_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_valid_q <= req_valid_d;
      req_ctrl_q  <= req_ctrl_d;
      req_src1_q  <= req_src1_d;
      req_src2_q  <= req_src2_d;
      rslt_q      <= rslt_d;
      err_q       <= err_d;
    end
  end

  assign stall_o     = busy || ((state_q == ST_IDLE) && valid_i);
  assign rslt_o      = rslt_q;
  assign err_o       = err_q;
  assign req_valid_o = req_valid_q;
  assign req_ctrl_o  = req_ctrl_q;
  assign req_src1_o  = req_src1_q;
  assign req_src2_o  = req_src2_q;

endmodule

// File: tb/tb_cfu_issue.sv
// Bench for cfu_issue: directed scenarios plus random traffic, all checked
// every cycle against a transaction-level reference model.
module tb_cfu_issue;
  import cfu_issue_pkg::*;

  localparam int XL = CFU_XLEN;
  localparam int CW = CFU_CTRL_WIDTH;
  localparam int TO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1, stall_i = 1'b0, valid_i = 1'b0;
  logic [CW-1:0] ctrl = '0;
  logic [XL-1:0] src1 = '0, src2 = '0, rsp_data = '0;
  logic          req_ready = 1'b0, rsp_valid = 1'b0;

  logic          stall_o, err_o, req_valid_o;
  logic [XL-1:0] rslt_o, req_src1_o, req_src2_o;
  logic [CW-1:0] req_ctrl_o;

  cfu_issue #(.XLEN(XL), .CTRL_WIDTH(CW), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall_i), .valid_i(valid_i),
    .cfu_ctrl_i(ctrl), .src1_i(src1), .src2_i(src2),
    .stall_o(stall_o), .rslt_o(rslt_o), .err_o(err_o),
    .req_valid_o(req_valid_o), .req_ctrl_o(req_ctrl_o),
    .req_src1_o(req_src1_o), .req_src2_o(req_src2_o),
    .req_ready_i(req_ready), .rsp_valid_i(rsp_valid), .rsp_data_i(rsp_data)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an instruction is outstanding (busy), possibly accepted,
  // then its result is held until the core retires it.
  bit            m_busy = 0, m_acc = 0, m_hold = 0, m_err = 0;
  int            m_age = 0;
  logic [XL-1:0] m_rslt = '0, m_s1 = '0, m_s2 = '0;
  logic [CW-1:0] m_ctrl = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 0; m_acc <= 0; m_hold <= 0; m_err <= 0; m_age <= 0;
      m_rslt <= '0; m_s1 <= '0; m_s2 <= '0; m_ctrl <= '0;
    end else if (m_hold) begin
      if (!stall_i) m_hold <= 0;
    end else if (m_busy) begin
      if (rsp_valid && (m_acc || req_ready)) begin
        m_rslt <= rsp_data; m_busy <= 0; m_hold <= 1;
      end else if (m_age == TO - 1) begin
        m_rslt <= '0; m_err <= 1; m_busy <= 0; m_hold <= 1;
      end else begin
        if (req_ready) m_acc <= 1;
        m_age <= m_age + 1;
      end
    end else if (valid_i) begin
      m_ctrl <= ctrl; m_s1 <= src1; m_s2 <= src2;
      m_busy <= 1; m_acc <= 0; m_age <= 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("m_stall",     64'(stall_o),     64'(m_busy || (!m_hold && valid_i)));
      cmp("m_rslt",      64'(rslt_o),      64'(m_rslt));
      cmp("m_err",       64'(err_o),       64'(m_err));
      cmp("m_req_valid", 64'(req_valid_o), 64'(m_busy && !m_acc));
      cmp("m_req_ctrl",  64'(req_ctrl_o),  64'(m_ctrl));
      cmp("m_req_src1",  64'(req_src1_o),  64'(m_s1));
      cmp("m_req_src2",  64'(req_src2_o),  64'(m_s2));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction. rdy_dly: REQ cycles before ready; rsp_dly: cycles
  // after acceptance until the response (0 = same cycle, -1 = never).
  task automatic run_op(input logic [CW-1:0] c, input logic [XL-1:0] a, input logic [XL-1:0] b,
                        input int rdy_dly, input int rsp_dly, input logic [XL-1:0] data,
                        input int hold, output logic [XL-1:0] res, output int cyc, output int rv);
    int  acc;
    bit  done;
    valid_i = 1; ctrl = c; src1 = a; src2 = b; req_ready = 0; rsp_valid = 0; stall_i = 0;
    #1;
    cmp("issue_stall", 64'(stall_o), 64'd1);
    tick();
    cyc = 0; acc = -1; done = 0; rv = 0;
    while (!done && cyc < 40) begin
      req_ready = (acc < 0) && (cyc >= rdy_dly);
      rsp_valid = (rsp_dly >= 0) &&
                  (((acc >= 0) && (cyc - acc >= rsp_dly)) || (req_ready && rsp_dly == 0));
      rsp_data  = data;
      if (req_valid_o) rv++;
      if (req_ready) acc = cyc;
      tick();
      cyc++;
      if (!stall_o) done = 1;
    end
    if (!done) cmp("op_bound", 64'(cyc), 64'd0);
    req_ready = 0; rsp_valid = 0;
    res = rslt_o;
    cmp("done_req_valid", 64'(req_valid_o), 64'd0);
    for (int i = 0; i < hold; i++) begin
      stall_i = 1;
      tick();
      cmp("hold_rslt", 64'(rslt_o), 64'(res));
      cmp("hold_stall", 64'(stall_o), 64'd0);
    end
    stall_i = 0; valid_i = 0;
    tick();
    cmp("retire_stall", 64'(stall_o), 64'd0);
    tick();
    cmp("retire_no_req", 64'(req_valid_o), 64'd0);
  endtask

  logic [XL-1:0] res;
  int            cyc, rv;

  initial begin
    repeat (3) tick();
    rst = 0;
    chk_en = 1;
    cmp("rst_rslt", 64'(rslt_o), 64'd0);
    cmp("rst_err", 64'(err_o), 64'd0);
    cmp("rst_req_valid", 64'(req_valid_o), 64'd0);

    run_op(CW'(1), 32'd5, 32'd7, 1, 3, 32'd12, 0, res, cyc, rv);
    cmp("fixed_rslt", 64'(res), 64'd12);
    cmp("fixed_cycles", 64'(cyc), 64'd5);
    cmp("fixed_err", 64'(err_o), 64'd0);

    run_op(CW'(2), 32'd1, 32'd2, 0, 0, 32'hDEADBEEF, 0, res, cyc, rv);
    cmp("zero_rslt", 64'(res), 64'hDEADBEEF);
    cmp("zero_cycles", 64'(cyc), 64'd1);
    cmp("zero_rv", 64'(rv), 64'd1);

    run_op(CW'(4), 32'd3, 32'd4, 0, 2, 32'h55, 4, res, cyc, rv);
    cmp("hold_val", 64'(res), 64'h55);
    cmp("hold_keep", 64'(rslt_o), 64'h55);

    run_op(CW'(5), 32'd9, 32'd9, 100, -1, 32'h1234, 0, res, cyc, rv);
    cmp("to_cycles", 64'(cyc), 64'd8);
    cmp("to_rslt", 64'(res), 64'd0);
    cmp("to_err", 64'(err_o), 64'd1);
    run_op(CW'(6), 32'd1, 32'd1, 0, 1, 32'hA1, 0, res, cyc, rv);
    run_op(CW'(7), 32'd2, 32'd2, 2, 0, 32'hA2, 1, res, cyc, rv);
    cmp("to_err_sticky", 64'(err_o), 64'd1);
    cmp("to_after_rslt", 64'(res), 64'hA2);

    // reset while waiting; the late response must not land
    valid_i = 1; ctrl = CW'(2); src1 = 32'd1; src2 = 32'd2;
    tick();
    req_ready = 1;
    tick();
    req_ready = 0; rst = 1;
    tick();
    rst = 0; valid_i = 0;
    #1;
    cmp("mrst_stall", 64'(stall_o), 64'd0);
    cmp("mrst_rv", 64'(req_valid_o), 64'd0);
    cmp("mrst_err", 64'(err_o), 64'd0);
    cmp("mrst_src1", 64'(req_src1_o), 64'd0);
    cmp("mrst_ctrl", 64'(req_ctrl_o), 64'd0);
    tick();
    rsp_valid = 1; rsp_data = 32'hBAD;
    tick();
    tick();
    rsp_valid = 0;
    cmp("late_rslt", 64'(rslt_o), 64'd0);
    cmp("late_stall", 64'(stall_o), 64'd0);

    // backpressure with operands changing underneath
    valid_i = 1; ctrl = CW'(3); src1 = 32'h11; src2 = 32'h22;
    tick();
    for (int i = 0; i < 5; i++) begin
      req_ready = 0; src1 = $urandom();
      tick();
      cmp("bp_valid", 64'(req_valid_o), 64'd1);
      cmp("bp_src1", 64'(req_src1_o), 64'h11);
      cmp("bp_src2", 64'(req_src2_o), 64'h22);
      cmp("bp_ctrl", 64'(req_ctrl_o), 64'd3);
    end
    req_ready = 1; rsp_valid = 1; rsp_data = 32'h99;
    tick();
    cmp("bp_rslt", 64'(rslt_o), 64'h99);
    req_ready = 0; rsp_valid = 0; valid_i = 0;
    tick();

    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 199) == 0);
      valid_i   = ($urandom_range(0, 2) != 0);
      stall_i   = ($urandom_range(0, 2) == 0);
      req_ready = ($urandom_range(0, 3) == 0);
      rsp_valid = ($urandom_range(0, 4) == 0);
      rsp_data  = $urandom();
      ctrl      = CW'($urandom());
      src1      = $urandom();
      src2      = $urandom();
      tick();
    end
    rst = 0; valid_i = 0; req_ready = 0; rsp_valid = 0; stall_i = 0;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
